// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator.
// Horizontal and vertical counters advance on a pixel-rate enable. Sync,
// blanking, coordinate and strobe outputs are all registered. They are
// decoded from the next-state counters, so they always match pixel_x/pixel_y
// on the same cycle and never glitch.
module vga_timing_gen #(
    parameter int CNT_W  = 10,
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    output logic             video_on,
    output logic             h_sync,
    output logic             v_sync,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    // Reject configurations that the counters cannot represent.
    if (CNT_W < 1 || CNT_W > 31 ||
        H_DISP < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_DISP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
        $error("vga_timing_gen: every timing parameter must be >= 1");
    end
    if (longint'(H_TOTAL) > (64'd1 << CNT_W) ||
        longint'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**CNT_W");
    end

    // Decode thresholds at counter width; all fit because each total <= 2**CNT_W.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             video_on_q, video_on_d;
    logic             h_sync_q, h_sync_d;
    logic             v_sync_q, v_sync_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // Next state and counter values: enable has priority over tick.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                h_d = '0;
                v_d = '0;
                if (en) begin
                    state_d       = RUN;
                    line_start_d  = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    h_d     = '0;
                    v_d     = '0;
                end else if (tick) begin
                    if (h_q == H_LAST) begin
                        h_d          = '0;
                        line_start_d = 1'b1;
                        if (v_q == V_LAST) begin
                            v_d           = '0;
                            frame_start_d = 1'b1;
                        end else begin
                            v_d = v_q + 1'b1;
                        end
                    end else begin
                        h_d = h_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode the next-state counters so outputs register alongside them.
    always_comb begin
        video_on_d = (state_d == RUN) && (h_d < H_ACT) && (v_d < V_ACT);
        h_sync_d   = ((state_d == RUN) && (h_d >= H_SYNC_S) && (h_d <= H_SYNC_E))
                     ? HS_POL : ~HS_POL;
        v_sync_d   = ((state_d == RUN) && (v_d >= V_SYNC_S) && (v_d <= V_SYNC_E))
                     ? VS_POL : ~VS_POL;
    end

    // State, counters and decoded outputs; reset returns everything to idle at once.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q       <= IDLE;
            h_q           <= '0;
            v_q           <= '0;
            video_on_q    <= 1'b0;
            h_sync_q      <= ~HS_POL;
            v_sync_q      <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            video_on_q    <= video_on_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign video_on    = video_on_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default 640x480 instance and a tiny
// active-high instance share one stimulus stream. Each is compared every cycle
// against a model that derives position from the number of ticks since start.
module tb_vga_timing_gen;

    typedef struct {
        int hd, hf, hs, hb;
        int vd, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic en = 1'b0;

    logic       vo0, hs0, vs0, ls0, fs0;
    logic [9:0] px0, py0;
    logic       vo1, hs1, vs1, ls1, fs1;
    logic [3:0] px1, py1;

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst), .tick(tick), .en(en),
        .video_on(vo0), .h_sync(hs0), .v_sync(vs0),
        .pixel_x(px0), .pixel_y(py0),
        .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .CNT_W(4), .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick), .en(en),
        .video_on(vo1), .h_sync(hs1), .v_sync(vs1),
        .pixel_x(px1), .pixel_y(py1),
        .line_start(ls1), .frame_start(fs1)
    );

    logic [31:0] o_px[2], o_py[2];
    logic        o_vo[2], o_hs[2], o_vs[2], o_ls[2], o_fs[2];
    assign o_px[0] = {22'd0, px0};
    assign o_py[0] = {22'd0, py0};
    assign o_px[1] = {28'd0, px1};
    assign o_py[1] = {28'd0, py1};
    assign o_vo[0] = vo0;  assign o_vo[1] = vo1;
    assign o_hs[0] = hs0;  assign o_hs[1] = hs1;
    assign o_vs[0] = vs0;  assign o_vs[1] = vs1;
    assign o_ls[0] = ls0;  assign o_ls[1] = ls1;
    assign o_fs[0] = fs0;  assign o_fs[1] = fs1;

    cfg_t cfg[2];
    initial begin
        cfg[0] = '{hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vf: 10, vs: 2, vb: 33, hp: 1'b0, vp: 1'b0};
        cfg[1] = '{hd: 4, hf: 1, hs: 2, hb: 1, vd: 3, vf: 1, vs: 1, vb: 1, hp: 1'b1, vp: 1'b1};
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: running flag, ticks elapsed since the run began, and strobes.
    bit     m_run[2];
    longint m_n[2];
    bit     m_ls[2], m_fs[2];

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_run[i] = 1'b0;
                m_n[i]   = 0;
                m_ls[i]  = 1'b0;
                m_fs[i]  = 1'b0;
            end else begin
                longint ht, vt;
                ht = cfg[i].hd + cfg[i].hf + cfg[i].hs + cfg[i].hb;
                vt = cfg[i].vd + cfg[i].vf + cfg[i].vs + cfg[i].vb;
                m_ls[i] = 1'b0;
                m_fs[i] = 1'b0;
                if (!m_run[i]) begin
                    if (en) begin
                        m_run[i] = 1'b1;
                        m_n[i]   = 0;
                        m_ls[i]  = 1'b1;
                        m_fs[i]  = 1'b1;
                    end
                end else if (!en) begin
                    m_run[i] = 1'b0;
                    m_n[i]   = 0;
                end else if (tick) begin
                    m_n[i]++;
                    m_ls[i] = (m_n[i] % ht) == 0;
                    m_fs[i] = (m_n[i] % (ht * vt)) == 0;
                end
            end
        end
    end

    task automatic check_outputs(input string ph);
        for (int i = 0; i < 2; i++) begin
            longint ht, vt, h, v;
            bit vo, hsa, vsa;
            ht = cfg[i].hd + cfg[i].hf + cfg[i].hs + cfg[i].hb;
            vt = cfg[i].vd + cfg[i].vf + cfg[i].vs + cfg[i].vb;
            h = m_run[i] ? (m_n[i] % ht) : 0;
            v = m_run[i] ? ((m_n[i] / ht) % vt) : 0;
            vo  = m_run[i] && h < cfg[i].hd && v < cfg[i].vd;
            hsa = m_run[i] && h >= cfg[i].hd + cfg[i].hf && h < cfg[i].hd + cfg[i].hf + cfg[i].hs;
            vsa = m_run[i] && v >= cfg[i].vd + cfg[i].vf && v < cfg[i].vd + cfg[i].vf + cfg[i].vs;
            check($sformatf("%s_d%0d_px", ph, i), o_px[i], 32'(h));
            check($sformatf("%s_d%0d_py", ph, i), o_py[i], 32'(v));
            check($sformatf("%s_d%0d_vo", ph, i), 32'(o_vo[i]), 32'(vo));
            check($sformatf("%s_d%0d_hs", ph, i), 32'(o_hs[i]), 32'(hsa ? cfg[i].hp : !cfg[i].hp));
            check($sformatf("%s_d%0d_vs", ph, i), 32'(o_vs[i]), 32'(vsa ? cfg[i].vp : !cfg[i].vp));
            check($sformatf("%s_d%0d_ls", ph, i), 32'(o_ls[i]), 32'(m_ls[i]));
            check($sformatf("%s_d%0d_fs", ph, i), 32'(o_fs[i]), 32'(m_fs[i]));
        end
    endtask

    // Period and pulse-width measurements from strobe to strobe.
    bit meas0 = 1'b0, meas1 = 1'b0;
    int l_seen0, l_last0, vo_cnt0, hs_cnt0;
    int l_seen1, l_last1, hs_cnt1, f_seen1, f_last1, vs_cnt1, vo_cnt1;

    task automatic measure();
        if (meas0) begin
            if (o_ls[0]) begin
                if (l_seen0 >= 2) begin
                    check("line_period0", cyc - l_last0, 3200);
                    check("vo_clks0", vo_cnt0, 2560);
                    check("hs_clks0", hs_cnt0, 384);
                end
                l_seen0++;
                l_last0 = cyc;
                vo_cnt0 = 0;
                hs_cnt0 = 0;
            end
            if (o_vo[0]) vo_cnt0++;
            if (!o_hs[0]) hs_cnt0++;
        end
        if (meas1) begin
            if (o_ls[1]) begin
                if (l_seen1 >= 2) begin
                    check("line_period1", cyc - l_last1, 8);
                    check("hs_clks1", hs_cnt1, 2);
                end
                l_seen1++;
                l_last1 = cyc;
                hs_cnt1 = 0;
            end
            if (o_fs[1]) begin
                if (f_seen1 >= 2) begin
                    check("frame_period1", cyc - f_last1, 48);
                    check("vs_clks1", vs_cnt1, 8);
                    check("vo_clks1", vo_cnt1, 12);
                end
                f_seen1++;
                f_last1 = cyc;
                vs_cnt1 = 0;
                vo_cnt1 = 0;
            end
            if (o_hs[1]) hs_cnt1++;
            if (o_vs[1]) vs_cnt1++;
            if (o_vo[1]) vo_cnt1++;
        end
    endtask

    task automatic step(input string ph);
        @(negedge clk);
        cyc++;
        check_outputs(ph);
        measure();
    endtask

    initial begin
        bit found;
        int d;

        // Reset: immediate idle values on both instances.
        #1 rst = 1'b0;
        #1;
        check("rst_px0", o_px[0], 0);
        check("rst_py0", o_py[0], 0);
        check("rst_vo0", 32'(vo0), 0);
        check("rst_hs0", 32'(hs0), 1);
        check("rst_vs0", 32'(vs0), 1);
        check("rst_ls0", 32'(ls0), 0);
        check("rst_fs0", 32'(fs0), 0);
        check("rst_hs1", 32'(hs1), 0);
        check("rst_vs1", 32'(vs1), 0);
        step("rst");
        step("rst");
        rst = 1'b1;

        // Released with en low: nothing moves even if tick toggles.
        for (int k = 0; k < 10; k++) begin
            tick = 1'(($urandom_range(0, 1)));
            step("idle");
        end

        // Default line timing with a tick every 4th clock.
        meas0 = 1'b1;
        l_seen0 = 0; l_last0 = 0; vo_cnt0 = 0; hs_cnt0 = 0;
        en = 1'b1;
        tick = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            step("tick4");
            tick = (cyc % 4 == 0);
        end
        meas0 = 1'b0;

        // Tick tied high: small instance line/frame periods.
        meas1 = 1'b1;
        l_seen1 = 0; l_last1 = 0; hs_cnt1 = 0;
        f_seen1 = 0; f_last1 = 0; vs_cnt1 = 0; vo_cnt1 = 0;
        tick = 1'b1;
        for (int k = 0; k < 300; k++) step("tick1");
        meas1 = 1'b0;

        // Abort at h=300 with tick on the same edge, then restart.
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            step("seek");
            if (o_px[0] == 300) found = 1'b1;
        end
        check("abort_wait", 32'(found), 1);
        en = 1'b0;
        tick = 1'b1;
        step("abort");
        check("abort_px0", o_px[0], 0);
        check("abort_vo0", 32'(vo0), 0);
        check("abort_ls0", 32'(ls0), 0);
        en = 1'b1;
        step("restart");
        check("restart_px0", o_px[0], 0);
        check("restart_vo0", 32'(vo0), 1);
        check("restart_ls0", 32'(ls0), 1);
        check("restart_fs0", 32'(fs0), 1);

        // Tick held low: everything holds, strobes clear.
        tick = 1'b0;
        for (int k = 0; k < 20; k++) step("hold");

        // Random ticks, occasional enable drops and mid-cycle async resets.
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                d = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 8));
                #d rst = 1'b0;
                #1 check_outputs("arst");
                step("arst");
                rst = 1'b1;
            end
            tick = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 99) != 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
